// File: rtl/mem_access_stage.sv
// MEM pipeline stage: EX/MEM register, ready-handshake data-memory port, MEM/WB register.
// Optional access timeout with sticky bus error is compiled in by defining MEM_TIMEOUT_EN.
module mem_access_stage #(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       i_alu_result,
    input  logic [31:0]       i_read_data_2,
    input  logic [4:0]        i_write_register,
    input  logic              i_reg_write,
    input  logic              i_mem_read,
    input  logic              i_mem_write,
    input  logic              i_mem_to_reg,
    input  logic              i_flush,
    output logic              o_stall,
    output logic              o_dmem_req,
    output logic              o_dmem_we,
    output logic [ADDR_W-1:0] o_dmem_addr,
    output logic [31:0]       o_dmem_wdata,
    input  logic              i_dmem_ready,
    input  logic [31:0]       i_dmem_rdata,
    output logic [4:0]        o_mem_write_register,
    output logic              o_mem_reg_write,
    output logic [31:0]       o_mem_alu_result,
    output logic [4:0]        o_wb_write_register,
    output logic              o_wb_reg_write,
    output logic [31:0]       o_wb_write_data,
    output logic              o_misaligned,
    output logic              o_bus_error,
    output logic              o_fsm_state
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t state;
    state_t next_state;

    logic [31:0] em_alu_result;
    logic [31:0] em_store_data;
    logic [4:0]  em_write_register;
    logic        em_reg_write;
    logic        em_mem_read;
    logic        em_mem_write;
    logic        em_mem_to_reg;

    logic [4:0]  wb_write_register;
    logic        wb_reg_write;
    logic [31:0] wb_write_data;
    logic        misaligned_q;

    logic mem_op;
    logic misal;
    logic abort;
    logic dmem_req;
    logic stall;

    // Handshake: o_dmem_req stays high with address/data/we stable until a cycle
    // in which i_dmem_ready is 1; that cycle completes the access (no separate ack).
    assign mem_op   = em_mem_read | em_mem_write;
    assign misal    = mem_op & (em_alu_result[1:0] != 2'b00);
    assign dmem_req = mem_op & ~misal & ~abort;
    assign stall    = dmem_req & ~i_dmem_ready;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] next_cnt;
    logic             bus_error_q;

    // Ready in the final wait cycle takes priority over the abort.
    assign abort = (state == S_WAIT) & ~i_dmem_ready & (wait_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (!reset) begin
            wait_cnt    <= '0;
            bus_error_q <= 1'b0;
        end else begin
            wait_cnt <= next_cnt;
            if (abort) begin
                bus_error_q <= 1'b1;
            end
        end
    end

    assign o_bus_error = bus_error_q;
`else
    logic unused_timeout_cfg;

    assign abort              = 1'b0;
    assign o_bus_error        = 1'b0;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
`ifdef MEM_TIMEOUT_EN
        next_cnt   = wait_cnt;
`endif
        case (state)
            S_IDLE: begin
                if (stall) begin
                    next_state = S_WAIT;
`ifdef MEM_TIMEOUT_EN
                    next_cnt   = '0;
`endif
                end
            end
            S_WAIT: begin
                if (i_dmem_ready || abort) begin
                    next_state = S_IDLE;
                end else begin
`ifdef MEM_TIMEOUT_EN
                    next_cnt = wait_cnt + 1'b1;
`endif
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    // EX/MEM: frozen while stalled, so a flush during a stall is dropped.
    always_ff @(posedge clk) begin
        if (!reset) begin
            em_alu_result     <= '0;
            em_store_data     <= '0;
            em_write_register <= '0;
            em_reg_write      <= 1'b0;
            em_mem_read       <= 1'b0;
            em_mem_write      <= 1'b0;
            em_mem_to_reg     <= 1'b0;
        end else if (!stall) begin
            if (i_flush) begin
                em_alu_result     <= '0;
                em_store_data     <= '0;
                em_write_register <= '0;
                em_reg_write      <= 1'b0;
                em_mem_read       <= 1'b0;
                em_mem_write      <= 1'b0;
                em_mem_to_reg     <= 1'b0;
            end else begin
                em_alu_result     <= i_alu_result;
                em_store_data     <= i_read_data_2;
                em_write_register <= i_write_register;
                em_reg_write      <= i_reg_write;
                em_mem_read       <= i_mem_read;
                em_mem_write      <= i_mem_write;
                em_mem_to_reg     <= i_mem_to_reg;
            end
        end
    end

    // MEM/WB: any cycle without a stall retires the EX/MEM instruction.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wb_write_register <= '0;
            wb_reg_write      <= 1'b0;
            wb_write_data     <= '0;
            misaligned_q      <= 1'b0;
        end else if (stall) begin
            wb_reg_write <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            wb_write_register <= em_write_register;
            wb_reg_write      <= em_reg_write & ~misal & ~abort;
            wb_write_data     <= em_mem_to_reg ? i_dmem_rdata : em_alu_result;
            misaligned_q      <= misal;
        end
    end

    assign o_stall              = stall;
    assign o_dmem_req           = dmem_req;
    assign o_dmem_we            = em_mem_write;
    assign o_dmem_addr          = em_alu_result[ADDR_W-1:0];
    assign o_dmem_wdata         = em_store_data;
    assign o_mem_write_register = em_write_register;
    assign o_mem_reg_write      = em_reg_write;
    assign o_mem_alu_result     = em_alu_result;
    assign o_wb_write_register  = wb_write_register;
    assign o_wb_reg_write       = wb_reg_write;
    assign o_wb_write_data      = wb_write_data;
    assign o_misaligned         = misaligned_q;
    assign o_fsm_state          = state;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed vectors, per-cycle compare against a
// transaction-level model, plus literal expectations. Timeout cases need MEM_TIMEOUT_EN.
module tb_mem_access_stage;
    localparam int ADDR_W = 32;
    localparam int TO_CYC = 4;
`ifdef MEM_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic [31:0] i_alu_result;
    logic [31:0] i_read_data_2;
    logic [4:0]  i_write_register;
    logic        i_reg_write, i_mem_read, i_mem_write, i_mem_to_reg, i_flush;
    logic        o_stall, o_dmem_req, o_dmem_we;
    logic [ADDR_W-1:0] o_dmem_addr;
    logic [31:0] o_dmem_wdata;
    logic        i_dmem_ready;
    logic [31:0] i_dmem_rdata;
    logic [4:0]  o_mem_write_register;
    logic        o_mem_reg_write;
    logic [31:0] o_mem_alu_result;
    logic [4:0]  o_wb_write_register;
    logic        o_wb_reg_write;
    logic [31:0] o_wb_write_data;
    logic        o_misaligned, o_bus_error, o_fsm_state;

    int pass_cnt  = 0;
    int total_cnt = 0;
    bit checking  = 1'b0;

    mem_access_stage #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TO_CYC)) dut (
        .clk(clk), .reset(reset),
        .i_alu_result(i_alu_result), .i_read_data_2(i_read_data_2),
        .i_write_register(i_write_register), .i_reg_write(i_reg_write),
        .i_mem_read(i_mem_read), .i_mem_write(i_mem_write),
        .i_mem_to_reg(i_mem_to_reg), .i_flush(i_flush),
        .o_stall(o_stall), .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we),
        .o_dmem_addr(o_dmem_addr), .o_dmem_wdata(o_dmem_wdata),
        .i_dmem_ready(i_dmem_ready), .i_dmem_rdata(i_dmem_rdata),
        .o_mem_write_register(o_mem_write_register), .o_mem_reg_write(o_mem_reg_write),
        .o_mem_alu_result(o_mem_alu_result), .o_wb_write_register(o_wb_write_register),
        .o_wb_reg_write(o_wb_reg_write), .o_wb_write_data(o_wb_write_data),
        .o_misaligned(o_misaligned), .o_bus_error(o_bus_error), .o_fsm_state(o_fsm_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- model ----------------
    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] wd;
        logic [4:0]  rd;
        logic        rw, mr, mw, m2r;
    } ex_t;

    typedef struct packed {
        logic req, stall, abort, mis;
    } comb_t;

    ex_t         m_slot;
    int          m_waited;
    logic        m_wb_rw;
    logic [4:0]  m_wb_rd;
    logic [31:0] m_wb_data;
    logic        m_mis;
    logic        m_berr;

    function automatic ex_t cur_ex();
        ex_t e;
        e.alu = i_alu_result; e.wd = i_read_data_2; e.rd = i_write_register;
        e.rw = i_reg_write; e.mr = i_mem_read; e.mw = i_mem_write; e.m2r = i_mem_to_reg;
        return e;
    endfunction

    // An aligned access that has already waited TO_CYC cycles without ready is aborted.
    function automatic comb_t model_comb();
        comb_t c;
        bit    mem_op;
        mem_op  = m_slot.mr || m_slot.mw;
        c.mis   = mem_op && ((m_slot.alu % 4) != 0);
        c.abort = TO_EN && mem_op && !c.mis && !i_dmem_ready && (m_waited >= TO_CYC);
        c.req   = mem_op && !c.mis && !c.abort;
        c.stall = c.req && !i_dmem_ready;
        return c;
    endfunction

    always @(posedge clk) begin
        if (!reset) begin
            m_slot <= '0; m_waited <= 0; m_wb_rw <= 1'b0; m_wb_rd <= '0;
            m_wb_data <= '0; m_mis <= 1'b0; m_berr <= 1'b0;
        end else if (model_comb().stall) begin
            m_waited <= m_waited + 1;
            m_wb_rw  <= 1'b0;
            m_mis    <= 1'b0;
        end else begin
            m_wb_rw   <= m_slot.rw && !model_comb().mis && !model_comb().abort;
            m_wb_data <= m_slot.m2r ? i_dmem_rdata : m_slot.alu;
            m_wb_rd   <= m_slot.rd;
            m_mis     <= model_comb().mis;
            m_berr    <= m_berr | model_comb().abort;
            m_waited  <= 0;
            m_slot    <= i_flush ? ex_t'('0) : cur_ex();
        end
    end

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (checking) begin
            chk("cmp_req",      32'(o_dmem_req),           32'(model_comb().req));
            chk("cmp_stall",    32'(o_stall),              32'(model_comb().stall));
            chk("cmp_we",       32'(o_dmem_we),            32'(m_slot.mw));
            chk("cmp_addr",     32'(o_dmem_addr),          m_slot.alu);
            chk("cmp_wdata",    o_dmem_wdata,              m_slot.wd);
            chk("cmp_mem_rd",   32'(o_mem_write_register), 32'(m_slot.rd));
            chk("cmp_mem_rw",   32'(o_mem_reg_write),      32'(m_slot.rw));
            chk("cmp_mem_alu",  o_mem_alu_result,          m_slot.alu);
            chk("cmp_wb_rd",    32'(o_wb_write_register),  32'(m_wb_rd));
            chk("cmp_wb_rw",    32'(o_wb_reg_write),       32'(m_wb_rw));
            chk("cmp_wb_data",  o_wb_write_data,           m_wb_data);
            chk("cmp_misal",    32'(o_misaligned),         32'(m_mis));
            chk("cmp_bus_err",  32'(o_bus_error),          32'(m_berr));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_ex(input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] rd,
                          input logic rw, input logic mr, input logic mw, input logic m2r);
        i_alu_result = alu; i_read_data_2 = wd; i_write_register = rd;
        i_reg_write = rw; i_mem_read = mr; i_mem_write = mw; i_mem_to_reg = m2r;
    endtask

    task automatic nop_ex();
        set_ex(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_stall"}, 32'(o_stall), 32'h0);
        chk({tag, "_req"}, 32'(o_dmem_req), 32'h0);
        chk({tag, "_we"}, 32'(o_dmem_we), 32'h0);
        chk({tag, "_addr"}, 32'(o_dmem_addr), 32'h0);
        chk({tag, "_wdata"}, o_dmem_wdata, 32'h0);
        chk({tag, "_mem_rd"}, 32'(o_mem_write_register), 32'h0);
        chk({tag, "_mem_rw"}, 32'(o_mem_reg_write), 32'h0);
        chk({tag, "_mem_alu"}, o_mem_alu_result, 32'h0);
        chk({tag, "_wb_rd"}, 32'(o_wb_write_register), 32'h0);
        chk({tag, "_wb_rw"}, 32'(o_wb_reg_write), 32'h0);
        chk({tag, "_wb_data"}, o_wb_write_data, 32'h0);
        chk({tag, "_misal"}, 32'(o_misaligned), 32'h0);
        chk({tag, "_bus_err"}, 32'(o_bus_error), 32'h0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int stalls;
        reset = 1'b0; i_flush = 1'b0; i_dmem_ready = 1'b0; i_dmem_rdata = 32'h0;
        nop_ex();

        // reset with random inputs
        for (int r = 0; r < 2; r++) begin
            set_ex($urandom, $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            i_flush = 1'($urandom_range(0, 1));
            i_dmem_ready = 1'($urandom_range(0, 1));
            i_dmem_rdata = $urandom;
            tick();
            checking = 1'b1;
            chk_all_zero("reset");
        end
        i_flush = 1'b0;

        // zero-wait LW
        reset = 1'b1;
        set_ex(32'h10, 32'h0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1);
        i_dmem_ready = 1'b1; i_dmem_rdata = 32'hCAFEF00D;
        tick();
        nop_ex();
        #1;
        chk("lw0_stall", 32'(o_stall), 32'h0);
        chk("lw0_req", 32'(o_dmem_req), 32'h1);
        chk("lw0_addr", 32'(o_dmem_addr), 32'h10);
        tick();
        chk("lw0_wb_data", o_wb_write_data, 32'hCAFEF00D);
        chk("lw0_wb_rw", 32'(o_wb_reg_write), 32'h1);
        chk("lw0_wb_rd", 32'(o_wb_write_register), 32'd5);

        // 3-wait SW followed by an R-type held on the EX outputs
        set_ex(32'h20, 32'h55, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        i_dmem_ready = 1'b0;
        tick();
        set_ex(32'h1234, 32'h0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        stalls = 0;
        for (int k = 0; k < 4; k++) begin
            i_dmem_ready = (k == 3);
            #1;
            chk("sw3_req", 32'(o_dmem_req), 32'h1);
            chk("sw3_we", 32'(o_dmem_we), 32'h1);
            chk("sw3_addr", 32'(o_dmem_addr), 32'h20);
            chk("sw3_wdata", o_dmem_wdata, 32'h55);
            if (o_stall) stalls++;
            tick();
            if (k < 3) chk("sw3_wb_bubble", 32'(o_wb_reg_write), 32'h0);
        end
        chk("sw3_stall_cycles", 32'(stalls), 32'd3);
        chk("sw3_wb_rw", 32'(o_wb_reg_write), 32'h0);
        chk("sw3_next_loaded", o_mem_alu_result, 32'h1234);
        nop_ex();
        tick();
        chk("rtype_wb_data", o_wb_write_data, 32'h1234);
        chk("rtype_wb_rw", 32'(o_wb_reg_write), 32'h1);
        chk("rtype_wb_rd", 32'(o_wb_write_register), 32'd7);

        // misaligned LW and SW
        set_ex(32'h13, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        nop_ex();
        #1;
        chk("mis_lw_req", 32'(o_dmem_req), 32'h0);
        chk("mis_lw_stall", 32'(o_stall), 32'h0);
        tick();
        chk("mis_lw_pulse", 32'(o_misaligned), 32'h1);
        chk("mis_lw_wb_rw", 32'(o_wb_reg_write), 32'h0);
        set_ex(32'h22, 32'hDEAD, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        chk("mis_pulse_end", 32'(o_misaligned), 32'h0);
        nop_ex();
        #1;
        chk("mis_sw_req", 32'(o_dmem_req), 32'h0);
        tick();
        chk("mis_sw_pulse", 32'(o_misaligned), 32'h1);

        // flush of an R-type, then flush while stalled
        set_ex(32'hABCD, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        nop_ex();
        #1;
        chk("flush_mem_rw", 32'(o_mem_reg_write), 32'h0);
        chk("flush_mem_alu", o_mem_alu_result, 32'h0);
        chk("flush_mem_rd", 32'(o_mem_write_register), 32'h0);
        tick();
        chk("flush_wb_rw", 32'(o_wb_reg_write), 32'h0);
        set_ex(32'h40, 32'h0, 5'd6, 1'b1, 1'b1, 1'b0, 1'b1);
        i_dmem_ready = 1'b0;
        tick();
        set_ex(32'h77, 32'h0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
        i_flush = 1'b1;
        tick();
        chk("flush_stall_hold", o_mem_alu_result, 32'h40);
        chk("flush_stall_req", 32'(o_dmem_req), 32'h1);
        i_flush = 1'b0; i_dmem_ready = 1'b1; i_dmem_rdata = 32'h11112222;
        tick();
        chk("flush_stall_wb_data", o_wb_write_data, 32'h11112222);
        chk("flush_stall_wb_rw", 32'(o_wb_reg_write), 32'h1);
        chk("flush_stall_wb_rd", 32'(o_wb_write_register), 32'd6);
        chk("flush_stall_next", o_mem_alu_result, 32'h77);
        nop_ex();
        tick();

        // back-to-back loads with ready held high
        i_dmem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            set_ex(32'h100 + 32'(4 * i), 32'h0, 5'(i + 1), 1'b1, 1'b1, 1'b0, 1'b1);
            i_dmem_rdata = 32'hA5000000 + 32'(i);
            #1;
            chk("b2b_stall", 32'(o_stall), 32'h0);
            tick();
            if (i >= 1) begin
                chk("b2b_wb_data", o_wb_write_data, 32'hA5000000 + 32'(i));
                chk("b2b_wb_rd", 32'(o_wb_write_register), 32'(i));
                chk("b2b_wb_rw", 32'(o_wb_reg_write), 32'h1);
            end
        end
        nop_ex();
        tick();

        // random traffic, EX outputs held while the model says stalled
        for (int n = 0; n < 60; n++) begin
            if (!model_comb().stall) begin
                case ($urandom_range(0, 3))
                    0: set_ex($urandom, $urandom, 5'($urandom_range(0, 31)), 1'b1, 1'b0, 1'b0, 1'b0);
                    1: set_ex(32'($urandom_range(0, 255)), 32'h0, 5'($urandom_range(0, 31)),
                              1'b1, 1'b1, 1'b0, 1'b1);
                    2: set_ex(32'($urandom_range(0, 255)), $urandom, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
                    default: nop_ex();
                endcase
                i_flush = ($urandom_range(0, 7) == 0);
            end
            i_dmem_ready = 1'($urandom_range(0, 1));
            i_dmem_rdata = $urandom;
            tick();
        end
        i_flush = 1'b0;
        nop_ex();

        // reset after activity
        i_dmem_ready = 1'b0;
        do_reset();
        chk_all_zero("reset2");

        // ready arriving in the last possible wait cycle
        set_ex(32'h60, 32'h0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        nop_ex();
        for (int k = 0; k < TO_CYC; k++) begin
            #1;
            chk("late_rdy_stall", 32'(o_stall), 32'h1);
            tick();
        end
        i_dmem_ready = 1'b1; i_dmem_rdata = 32'h5EED5EED;
        #1;
        chk("late_rdy_no_stall", 32'(o_stall), 32'h0);
        chk("late_rdy_req", 32'(o_dmem_req), 32'h1);
        tick();
        chk("late_rdy_wb_data", o_wb_write_data, 32'h5EED5EED);
        chk("late_rdy_wb_rw", 32'(o_wb_reg_write), 32'h1);
        chk("late_rdy_bus_err", 32'(o_bus_error), 32'h0);

        // ready never comes
        i_dmem_ready = 1'b0;
        set_ex(32'h80, 32'h0, 5'd2, 1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        set_ex(32'h99, 32'h0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        stalls = 0;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (!o_stall) break;
            stalls++;
            tick();
        end
        if (TO_EN) begin
            chk("to_stall_cycles", 32'(stalls), 32'(TO_CYC));
            chk("to_abort_req", 32'(o_dmem_req), 32'h0);
            tick();
            chk("to_bus_err", 32'(o_bus_error), 32'h1);
            chk("to_wb_rw", 32'(o_wb_reg_write), 32'h0);
            nop_ex();
            tick();
            chk("to_resume_wb_data", o_wb_write_data, 32'h99);
            chk("to_resume_wb_rw", 32'(o_wb_reg_write), 32'h1);
            tick();
            chk("to_bus_err_sticky", 32'(o_bus_error), 32'h1);
        end else begin
            chk("nto_stall_cycles", 32'(stalls), 32'd20);
            chk("nto_bus_err", 32'(o_bus_error), 32'h0);
            i_dmem_ready = 1'b1; i_dmem_rdata = 32'h0BADF00D;
            tick();
            chk("nto_wb_data", o_wb_write_data, 32'h0BADF00D);
            chk("nto_wb_rw", 32'(o_wb_reg_write), 32'h1);
            nop_ex();
            tick();
        end
        i_dmem_ready = 1'b0;
        do_reset();
        chk("bus_err_cleared", 32'(o_bus_error), 32'h0);

        // reset in the middle of a pending access
        set_ex(32'h44, 32'h0, 5'd10, 1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        nop_ex();
        tick();
        chk("mid_pending_req", 32'(o_dmem_req), 32'h1);
        do_reset();
        chk("mid_rst_req", 32'(o_dmem_req), 32'h0);
        chk("mid_rst_stall", 32'(o_stall), 32'h0);
        chk("mid_rst_fsm", 32'(o_fsm_state), 32'h0);
        tick();
        tick();

        checking = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
